// File: rtl/processador.sv
// Four-step multi-cycle 16-bit processor: eight registers, one shared bus,
// and an A/G register pair around a single ALU. The bus value is exported.
module processador (
    input  logic        clock,
    input  logic        resetn,
    input  logic [15:0] iin,
    output logic [15:0] bus
);

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_NOP = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_MVI = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    logic [1:0]  step_q, step_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] a_q, a_d;
    logic [15:0] g_q, g_d;
    logic [15:0] r_q [8];
    logic [15:0] r_d [8];

    logic [2:0]  op;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic [15:0] imm;
    logic        is_alu;

    assign op     = ir_q[15:13];
    assign rx     = ir_q[12:10];
    assign ry     = ir_q[9:7];
    assign imm    = {6'd0, ir_q[9:0]};
    assign is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                    (op == OP_OR)  || (op == OP_XOR);

    // Carry and borrow fall off the top: results are modulo 2^16.
    function automatic logic [15:0] alu(input logic [2:0] f,
                                        input logic [15:0] x,
                                        input logic [15:0] y);
        logic [15:0] res;
        case (f)
            OP_ADD:  res = x + y;
            OP_SUB:  res = x - y;
            OP_AND:  res = x & y;
            OP_OR:   res = x | y;
            OP_XOR:  res = x ^ y;
            default: res = 16'd0;
        endcase
        return res;
    endfunction

    always_comb begin
        bus = 16'd0;
        case (step_q)
            2'd1: begin
                if (op == OP_MV)       bus = r_q[ry];
                else if (op == OP_MVI) bus = imm;
                else if (is_alu)       bus = r_q[rx];
            end
            2'd2: if (is_alu) bus = r_q[ry];
            2'd3: if (is_alu) bus = g_q;
            default: bus = 16'd0;
        endcase
    end

    always_comb begin
        step_d = step_q + 2'd1;
        ir_d   = ir_q;
        a_d    = a_q;
        g_d    = g_q;
        r_d    = r_q;
        case (step_q)
            2'd0: ir_d = iin;
            2'd1: begin
                if (op == OP_MV || op == OP_MVI) r_d[rx] = bus;
                else if (is_alu)                 a_d     = bus;
            end
            2'd2: if (is_alu) g_d = alu(op, a_q, bus);
            2'd3: if (is_alu) r_d[rx] = bus;
            default: ;
        endcase
    end

    // resetn is active-high; a reset mid-instruction discards it and restarts at T0.
    always_ff @(posedge clock) begin
        if (resetn) begin
            step_q <= 2'd0;
            ir_q   <= 16'd0;
            a_q    <= 16'd0;
            g_q    <= 16'd0;
            for (int i = 0; i < 8; i++) r_q[i] <= 16'd0;
        end else begin
            step_q <= step_d;
            ir_q   <= ir_d;
            a_q    <= a_d;
            g_q    <= g_d;
            for (int i = 0; i < 8; i++) r_q[i] <= r_d[i];
        end
    end

endmodule

// File: tb/tb_processador.sv
// Scoreboard bench for processador: each issued instruction queues its four
// expected bus values; a negedge monitor pops and compares one per cycle.
module tb_processador;

    logic        clock;
    logic        resetn;
    logic [15:0] iin;
    logic [15:0] bus;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q  [$];
    string       name_q [$];

    processador dut (
        .clock  (clock),
        .resetn (resetn),
        .iin    (iin),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [15:0] e;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (bus !== e) begin
                failures++;
                $display("FAIL %s: bus=%h expected=%h at %0t", n, bus, e, $time);
            end
        end
    end

    task automatic expect_bus(input string n, input logic [15:0] v);
        exp_q.push_back(v);
        name_q.push_back(n);
    endtask

    // Called just after an edge while the DUT sits in T0.
    task automatic run_instr(input string n, input logic [15:0] instr,
                             input logic [15:0] e1, input logic [15:0] e2,
                             input logic [15:0] e3);
        iin = instr;
        expect_bus({n, ".T0"}, 16'h0000);
        expect_bus({n, ".T1"}, e1);
        expect_bus({n, ".T2"}, e2);
        expect_bus({n, ".T3"}, e3);
        @(posedge clock); #1;
        iin = 16'hFFFF;
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin
        resetn = 1'b1;
        iin    = 16'h0000;
        expect_bus("reset_bus", 16'h0000);
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b0;

        run_instr("nop",        16'h2000, 16'h0000, 16'h0000, 16'h0000);
        run_instr("mvi_r0_1",   16'hA001, 16'h0001, 16'h0000, 16'h0000);
        run_instr("mvi_r1_0",   16'hA400, 16'h0000, 16'h0000, 16'h0000);
        run_instr("mv_r3_r0",   16'h0C00, 16'h0001, 16'h0000, 16'h0000);
        run_instr("mv_r3_r1",   16'h0C80, 16'h0000, 16'h0000, 16'h0000);
        run_instr("add_r1_r0",  16'h4400, 16'h0000, 16'h0001, 16'h0001);
        run_instr("and_r1_r0",  16'h8400, 16'h0001, 16'h0001, 16'h0001);
        run_instr("mvi_r2_0",   16'hA800, 16'h0000, 16'h0000, 16'h0000);
        run_instr("sub_wrap",   16'h6800, 16'h0000, 16'h0001, 16'hFFFF);
        run_instr("add_wrap",   16'h4800, 16'hFFFF, 16'h0001, 16'h0000);
        run_instr("mvi_r4_3ff", 16'hB3FF, 16'h03FF, 16'h0000, 16'h0000);
        run_instr("xor_r4_r0",  16'hF000, 16'h03FF, 16'h0001, 16'h03FE);
        run_instr("or_r4_r0",   16'hD000, 16'h03FE, 16'h0001, 16'h03FF);
        run_instr("add_r4_r4",  16'h5200, 16'h03FF, 16'h03FF, 16'h07FE);
        run_instr("mv_r5_r4",   16'h1600, 16'h07FE, 16'h0000, 16'h0000);
        run_instr("mv_r4_r4",   16'h1200, 16'h07FE, 16'h0000, 16'h0000);
        run_instr("mv_r5_r4b",  16'h1600, 16'h07FE, 16'h0000, 16'h0000);

        // add R4,R0 aborted by a reset sampled on the edge ending T2
        iin = 16'h5000;
        expect_bus("abort.T0", 16'h0000);
        expect_bus("abort.T1", 16'h07FE);
        expect_bus("abort.T2", 16'h0001);
        @(posedge clock); #1;
        iin = 16'hFFFF;
        @(posedge clock); #1;
        resetn = 1'b1;
        @(posedge clock); #1;
        resetn = 1'b0;

        run_instr("post_mv_r3_r0", 16'h0C00, 16'h0000, 16'h0000, 16'h0000);
        run_instr("post_mv_r3_r4", 16'h0E00, 16'h0000, 16'h0000, 16'h0000);
        run_instr("post_add_r4",   16'h5000, 16'h0000, 16'h0000, 16'h0000);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: time=%0t limit=20000", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
